// File: rtl/arm_wb_pkg.sv
// Shared definitions for the writeback write sequencer.
// Holds the sequencer state encoding and the default widths. It also holds the
// register index that is steered to the PC write path, because the register
// file does not store R15.
package arm_wb_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 4;
    localparam logic [3:0] PC_ADDR_DEF = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        W_LO = 2'd1,
        W_HI = 2'd2
    } wb_state_t;

endpackage

// File: rtl/wb_write_sequencer.sv
// Writeback write sequencer.
// This block accepts one completed result per valid/ready handshake. The result
// is either 32 bits or a 64-bit long-multiply pair. The block turns each result
// into registered single-port write beats: lo first, then hi for 64-bit results.
// A beat whose address is PC_ADDR goes to the PC strobe instead of the register file.
//
// Ports:
//   clk        core clock, rising edge
//   reset      synchronous reset, active low
//   res_valid  result offered          res_ready  sequencer can accept
//   res_wen    condition passed (0 = accept and discard)
//   res_64b    two-beat result
//   res_rd_lo  low / only destination  res_rd_hi  high destination
//   res_lo     low / only data         res_hi     high data
//   rf_we/rf_wa/rf_wd   register file write port (wa/wd hold when idle)
//   pc_we/pc_wd         PC write strobe and data (wd holds when idle)
//   busy       a write beat is in progress
//
// state | meaning
// IDLE  | no beat this cycle
// W_LO  | low (or only) word beat on the outputs
// W_HI  | high word beat of a 64-bit result on the outputs
module wb_write_sequencer
    import arm_wb_pkg::*;
#(
    parameter int              DATA_W  = DATA_W_DEF,
    parameter int              ADDR_W  = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] PC_ADDR = PC_ADDR_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic              res_wen,
    input  logic              res_64b,
    input  logic [ADDR_W-1:0] res_rd_lo,
    input  logic [ADDR_W-1:0] res_rd_hi,
    input  logic [DATA_W-1:0] res_lo,
    input  logic [DATA_W-1:0] res_hi,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wa,
    output logic [DATA_W-1:0] rf_wd,
    output logic              pc_we,
    output logic [DATA_W-1:0] pc_wd,
    output logic              busy
);

    wb_state_t         state, state_nxt;
    logic [DATA_W-1:0] lo_q, hi_q;
    logic [ADDR_W-1:0] alo_q, ahi_q;
    logic              is64_q;

    logic              accept;
    logic              beat_vld;
    logic [ADDR_W-1:0] beat_addr;
    logic [DATA_W-1:0] beat_data;

    // Next-state logic. The next beat is computed here as well, so the beat
    // outputs can be registered and still appear in the same cycle as the new state.
    always_comb begin
        res_ready = 1'b0;
        state_nxt = IDLE;
        beat_vld  = 1'b0;
        beat_addr = alo_q;
        beat_data = lo_q;

        if (reset) begin
            res_ready = !((state == W_LO) && is64_q);
        end
        accept = res_valid && res_ready;

        case (state)
            W_LO: begin
                if (is64_q) begin
                    state_nxt = W_HI;
                end else if (accept && res_wen) begin
                    state_nxt = W_LO;
                end
            end
            W_HI, IDLE: begin
                if (accept && res_wen) begin
                    state_nxt = W_LO;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // W_LO is only ever entered from a fresh accept, so its beat uses the
        // live inputs. W_HI always uses the captured high half.
        case (state_nxt)
            W_LO: begin
                beat_vld  = 1'b1;
                beat_addr = res_rd_lo;
                beat_data = res_lo;
            end
            W_HI: begin
                beat_vld  = 1'b1;
                beat_addr = ahi_q;
                beat_data = hi_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Discarded results (res_wen=0) leave the capture bank untouched.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lo_q   <= '0;
            hi_q   <= '0;
            alo_q  <= '0;
            ahi_q  <= '0;
            is64_q <= 1'b0;
        end else if (accept && res_wen) begin
            lo_q   <= res_lo;
            hi_q   <= res_hi;
            alo_q  <= res_rd_lo;
            ahi_q  <= res_rd_hi;
            is64_q <= res_64b;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rf_we <= 1'b0;
            rf_wa <= '0;
            rf_wd <= '0;
            pc_we <= 1'b0;
            pc_wd <= '0;
        end else begin
            rf_we <= beat_vld && (beat_addr != PC_ADDR);
            pc_we <= beat_vld && (beat_addr == PC_ADDR);
            if (beat_vld && (beat_addr != PC_ADDR)) begin
                rf_wa <= beat_addr;
                rf_wd <= beat_data;
            end
            if (beat_vld && (beat_addr == PC_ADDR)) begin
                pc_wd <= beat_data;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_wb_write_sequencer.sv
module tb_wb_write_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        res_valid, res_ready, res_wen, res_64b;
    logic [3:0]  res_rd_lo, res_rd_hi;
    logic [31:0] res_lo, res_hi;
    logic        rf_we, pc_we, busy;
    logic [3:0]  rf_wa;
    logic [31:0] rf_wd, pc_wd;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_write_sequencer dut (
        .clk(clk), .reset(reset),
        .res_valid(res_valid), .res_ready(res_ready), .res_wen(res_wen),
        .res_64b(res_64b), .res_rd_lo(res_rd_lo), .res_rd_hi(res_rd_hi),
        .res_lo(res_lo), .res_hi(res_hi),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .pc_we(pc_we), .pc_wd(pc_wd), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic offer(input logic wen, input logic b64, input logic [3:0] alo,
                         input logic [3:0] ahi, input logic [31:0] lo, input logic [31:0] hi);
        res_valid = 1'b1;
        res_wen   = wen;
        res_64b   = b64;
        res_rd_lo = alo;
        res_rd_hi = ahi;
        res_lo    = lo;
        res_hi    = hi;
    endtask

    task automatic rf_beat(input string tag, input logic [3:0] a, input logic [31:0] d);
        check({tag, ".rf_we"}, 32'(rf_we), 32'd1);
        check({tag, ".pc_we"}, 32'(pc_we), 32'd0);
        check({tag, ".rf_wa"}, 32'(rf_wa), 32'(a));
        check({tag, ".rf_wd"}, rf_wd, d);
    endtask

    task automatic quiet(input string tag);
        check({tag, ".rf_we"}, 32'(rf_we), 32'd0);
        check({tag, ".pc_we"}, 32'(pc_we), 32'd0);
        check({tag, ".busy"},  32'(busy),  32'd0);
    endtask

    initial begin
        reset = 1'b0;
        offer(1'b1, 1'b0, 4'd1, 4'd0, 32'h1234, 32'h0);

        // reset held with valid asserted
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst.ready", 32'(res_ready), 32'd0);
            quiet("rst");
        end
        reset = 1'b1;
        res_valid = 1'b0;
        @(negedge clk);
        check("idle.ready", 32'(res_ready), 32'd1);
        quiet("idle");

        // single 32-bit write
        offer(1'b1, 1'b0, 4'd3, 4'd0, 32'hDEADBEEF, 32'h0);
        @(negedge clk);
        rf_beat("w32", 4'd3, 32'hDEADBEEF);
        check("w32.busy", 32'(busy), 32'd1);
        res_valid = 1'b0;
        @(negedge clk);
        quiet("w32.after");
        check("w32.hold_wa", 32'(rf_wa), 32'd3);
        check("w32.hold_wd", rf_wd, 32'hDEADBEEF);

        // 64-bit followed back-to-back by a held 32-bit
        offer(1'b1, 1'b1, 4'd4, 4'd5, 32'h1, 32'h2);
        @(negedge clk);
        rf_beat("w64.lo", 4'd4, 32'h1);
        offer(1'b1, 1'b0, 4'd6, 4'd0, 32'h7, 32'h0);
        #1;
        check("w64.lo.ready", 32'(res_ready), 32'd0);
        @(negedge clk);
        rf_beat("w64.hi", 4'd5, 32'h2);
        check("w64.hi.ready", 32'(res_ready), 32'd1);
        @(negedge clk);
        rf_beat("b2b.w32", 4'd6, 32'h7);
        res_valid = 1'b0;
        @(negedge clk);
        quiet("b2b.after");

        // write to R15 goes to the PC strobe
        offer(1'b1, 1'b0, 4'd15, 4'd0, 32'h100, 32'h0);
        @(negedge clk);
        check("pc.pc_we", 32'(pc_we), 32'd1);
        check("pc.pc_wd", pc_wd, 32'h100);
        check("pc.rf_we", 32'(rf_we), 32'd0);
        check("pc.rf_wa_hold", 32'(rf_wa), 32'd6);
        res_valid = 1'b0;
        @(negedge clk);
        quiet("pc.after");
        check("pc.wd_hold", pc_wd, 32'h100);

        // discarded 64-bit result, then a real one the following cycle
        offer(1'b0, 1'b1, 4'd8, 4'd9, 32'hAA, 32'hBB);
        @(negedge clk);
        quiet("nowen");
        check("nowen.ready", 32'(res_ready), 32'd1);
        offer(1'b1, 1'b0, 4'd2, 4'd0, 32'h55, 32'h0);
        @(negedge clk);
        rf_beat("nowen.next", 4'd2, 32'h55);
        res_valid = 1'b0;
        @(negedge clk);
        quiet("nowen.idle");

        // 64-bit with hi half aimed at R15
        offer(1'b1, 1'b1, 4'd8, 4'd15, 32'hAA, 32'hBB);
        @(negedge clk);
        rf_beat("split.lo", 4'd8, 32'hAA);
        res_valid = 1'b0;
        @(negedge clk);
        check("split.hi.pc_we", 32'(pc_we), 32'd1);
        check("split.hi.rf_we", 32'(rf_we), 32'd0);
        check("split.hi.pc_wd", pc_wd, 32'hBB);
        @(negedge clk);
        quiet("split.after");

        // same destination for both halves: hi lands last
        offer(1'b1, 1'b1, 4'd9, 4'd9, 32'h11, 32'h22);
        @(negedge clk);
        rf_beat("same.lo", 4'd9, 32'h11);
        res_valid = 1'b0;
        @(negedge clk);
        rf_beat("same.hi", 4'd9, 32'h22);
        @(negedge clk);
        quiet("same.after");

        // reset during the lo beat drops the hi beat
        offer(1'b1, 1'b1, 4'd10, 4'd11, 32'h33, 32'h44);
        @(negedge clk);
        rf_beat("rstmid.lo", 4'd10, 32'h33);
        res_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("rstmid.ready", 32'(res_ready), 32'd0);
        @(negedge clk);
        quiet("rstmid.rst");
        check("rstmid.rf_wa", 32'(rf_wa), 32'd0);
        check("rstmid.rf_wd", rf_wd, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        quiet("rstmid.rel");
        check("rstmid.ready1", 32'(res_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/wb_write_sequencer.md
Name: wb_write_sequencer

Overview:
- Writeback-side producer for the register file write port in the multicycle ARM core.
- Accepts one completed result per handshake: either a 32-bit result, or a 64-bit long-multiply result (RdLo/RdHi).
- Turns each result into registered single-port write beats: one beat for 32-bit, two consecutive beats (lo, then hi) for 64-bit.
- Writes addressed to R15 are routed to a separate PC write strobe, because the register file does not store R15.

Parameters:
- DATA_W, 32, width of each data word and of the register file write data.
- ADDR_W, 4, register address width.
- PC_ADDR, 4'hF, register index that is redirected to the PC write path.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  synchronous reset, active-low (asserted when 0), sampled on the rising edge of clk.
- res_valid  in  1  result offered.
- res_ready  out  1  sequencer can accept; a transfer occurs when res_valid && res_ready at a clock edge.
- res_wen  in  1  condition passed; 0 = accept and discard, no write.
- res_64b  in  1  1 = 64-bit result (two writes).
- res_rd_lo  in  ADDR_W  destination for the low word, or the only destination for a 32-bit result.
- res_rd_hi  in  ADDR_W  destination for the high word; ignored when res_64b=0.
- res_lo  in  DATA_W  low word, or the whole 32-bit result.
- res_hi  in  DATA_W  high word.
- rf_we  out  1  register file write enable.
- rf_wa  out  ADDR_W  register file write address.
- rf_wd  out  DATA_W  register file write data.
- pc_we  out  1  PC write strobe.
- pc_wd  out  DATA_W  PC write data.
- busy  out  1  a write beat is in progress (state != IDLE).

Behaviour:
- States: IDLE, W_LO, W_HI. Captured registers: lo_q, hi_q, alo_q, ahi_q, is64_q.
- Reset (reset==0 at an edge):
  - state=IDLE.
  - rf_we=0, pc_we=0, rf_wa=0, rf_wd=0, pc_wd=0, busy=0.
  - res_ready=0 while reset is low.
  - A pending W_HI beat is dropped; the high word is never written.
- res_ready is combinational:
  - 1 in IDLE.
  - 1 in W_LO when is64_q=0.
  - 1 in W_HI.
  - 0 in W_LO when is64_q=1.
- On an accept at edge t:
  - Capture all res_* fields.
  - If res_wen=1, next state is W_LO; otherwise next state is IDLE, with no write and no capture side effects.
- Exit from W_LO:
  - If is64_q=1, go to W_HI.
  - Else, if a new accept with res_wen=1 occurs, go to W_LO.
  - Else, go to IDLE.
- Exit from W_HI: if a new accept with res_wen=1 occurs, go to W_LO; else go to IDLE.
- Outputs are registered and driven by state:
  - In W_LO: beat target is (alo_q, lo_q).
  - In W_HI: beat target is (ahi_q, hi_q).
  - If the beat target address == PC_ADDR: pc_we=1, pc_wd=data, rf_we=0.
  - Otherwise: rf_we=1, rf_wa=addr, rf_wd=data, pc_we=0.
- Latency:
  - 32-bit result accepted at edge t: write is visible in cycle t+1.
  - 64-bit result accepted at edge t: lo in cycle t+1, hi in cycle t+2.
- Throughput: one 32-bit result per cycle; one 64-bit result per two cycles. There are no bubbles between results while res_valid stays high.
- When rf_we=0, rf_wa and rf_wd hold their last values. When pc_we=0, pc_wd holds its last value.
- res_rd_lo == res_rd_hi on a 64-bit result: both beats are issued; the hi write lands last and wins.
- res_64b with only one half targeting PC_ADDR: that half goes to pc_we, the other half goes to rf_we, in their respective beats.
- res_valid=1 while res_ready=0: the input is held upstream, and no field is sampled.

Decomposition:
- Shared package (arm_wb_pkg): state encoding wb_state_t (IDLE=2'd0, W_LO=2'd1, W_HI=2'd2), PC_ADDR constant, DATA_W/ADDR_W defaults.
- No sub-module. A single FSM plus a capture register bank is natural at this size.

Test Plan:
- Reset held low 3 cycles with res_valid=1 -> res_ready=0, rf_we=0, pc_we=0, busy=0; after release, res_ready=1 in IDLE.
- 32-bit accept rd_lo=3, lo=32'hDEADBEEF at edge t -> cycle t+1: rf_we=1, rf_wa=3, rf_wd=32'hDEADBEEF; cycle t+2: rf_we=0.
- 64-bit accept rd_lo=4, rd_hi=5, lo=32'h1, hi=32'h2, followed immediately by a 32-bit rd=6, data=32'h7 held valid -> res_ready=0 in the W_LO beat; writes r4=1 (t+1), r5=2 (t+2), r6=7 (t+3); no gaps.
- 32-bit rd_lo=15, data=32'h100 -> pc_we=1, pc_wd=32'h100, rf_we=0 for one cycle.
- res_wen=0, res_64b=1 accepted -> no rf_we/pc_we pulse; busy stays 0; next result is accepted the following cycle.
- 64-bit accept, then reset=0 during the W_LO beat -> the W_HI write never occurs; state=IDLE and rf_we=0 on the cycle after reset.
